i2c_passthru_dir_ctrl_mc: RTL
=============================

Name: i2c_passthru_dir_ctrl_mc

Overview:
Parametrised direction/bit-sequencing controller for the I2C passthrough. It decides, per bit, whether the upstream master (channel A) or a downstream slave drives SDA, and pulses the bit engines via o_start. It generalises the single-downstream controller with these additions:
- NUM_CH downstream channels.
- STOP detection with an IDLE state.
- Saturating byte counter.
- Optional stuck-bit timeout.

Parameters:
NUM_CH, 2, number of downstream (channel B) buses; legal range 1..8.
BYTE_CNT_W, 8, width of o_byte_cnt.
TIMEOUT_W, 16, width of the timeout counter; used only with I2C_PASSTHRU_TIMEOUT_EN.
TIMEOUT_CYC, 50000, clk cycles allowed in a WAIT state before timeout.

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous, active-high reset
i_cha_scl  in  1  upstream SCL, already synchronised
i_cha_sda  in  1  upstream SDA, already synchronised
i_chb_scl  in  NUM_CH  downstream SCLs
i_chb_sda  in  NUM_CH  downstream SDAs
i_rx_done  in  1  receive engine finished current bit
i_tx_done  in  1  transmit engine finished current bit
i_rx_sda_init_valid  in  1  i_rx_sda_init holds the sampled bit value
i_rx_sda_init  in  1  sampled SDA value of the current bit
o_start  out  1  one-cycle pulse: begin next bit
o_tx_to_mst  out  1  1 = slave drives, forward toward master; 0 = master drives
o_busy  out  1  transaction in progress (state != IDLE)
o_byte_cnt  out  BYTE_CNT_W  completed bytes since START, saturating
o_timeout  out  1  stuck-bit flag; constant 0 when the feature is compiled out

Behaviour:
Reset (async, i_rst=1):
- state=IDLE, bit_cnt=0, first_byte_n=0, read_mode=0, ack_failed=0, byte_cnt=0, timeout counter=0.
- All outputs 0.
- prev_sda registers reset to 1.

Bus event detection (registered prev SDA per bus):
- START on a bus: SCL=1 and SDA falling.
- STOP on a bus: SCL=1 and SDA rising.
- any_start / any_stop = OR over channel A and all NUM_CH B buses.

Priority each cycle: any_start > any_stop > normal FSM.
- any_start: state=MST_RX_WAIT; clear bit_cnt, first_byte_n, read_mode, ack_failed, byte_cnt, timeout; o_start=0 that cycle.
- any_stop: state=IDLE; same clears.

Direction decision (slv_next):
- slv_next=1 if (bit_cnt==8 and !read_mode), i.e. slave ACKs a write byte.
- slv_next=1 if (bit_cnt!=8 and read_mode and !ack_failed).
- Otherwise slv_next=0.

States:
- IDLE: outputs 0; i_rx_done/i_tx_done ignored. Exit only on START.
- MST_RX_WAIT: o_tx_to_mst=0. When i_rx_done && i_tx_done: go to SLV_RX_START if slv_next, else MST_RX_START.
- MST_RX_START: o_start=1, increment bit; go to MST_RX_WAIT. Lasts exactly 1 cycle.
- SLV_RX_WAIT: o_tx_to_mst=1; same exit rule as MST_RX_WAIT.
- SLV_RX_START: o_start=1, o_tx_to_mst=1, increment bit; go to SLV_RX_WAIT.
- TIMEOUT (feature only): o_timeout=1, o_start=0, o_tx_to_mst=0. Exit only on START (to MST_RX_WAIT) or STOP (to IDLE).

Latency: o_start asserts exactly 1 cycle after the cycle in which both done inputs are seen high.

Bit counter:
- 0..9. On increment, 9 wraps to 1, otherwise +1.
- Sampling rules below apply whenever i_rx_sda_init_valid=1 and the bit_cnt condition holds, in any state.

Flag rules:
- first_byte_n sets to 1 whenever bit_cnt==9.
- read_mode := i_rx_sda_init when bit_cnt==8, first_byte_n==0, and i_rx_sda_init_valid.
- ack_failed := i_rx_sda_init when bit_cnt==9, i_rx_sda_init_valid, and ack_failed==0. Sticky until START/STOP.

Byte counter:
- Increments on each increment where bit_cnt==9.
- Saturates at 2^BYTE_CNT_W-1; no wrap.

Optional Feature:
Macro I2C_PASSTHRU_TIMEOUT_EN.
- Defined: timeout counter increments each cycle in MST_RX_WAIT or SLV_RX_WAIT. It clears on every o_start, START, and STOP. When it reaches TIMEOUT_CYC, the FSM enters TIMEOUT next cycle.
- Undefined: no counter or TIMEOUT state; o_timeout is tied to 0. Parameters TIMEOUT_W and TIMEOUT_CYC are unused.

Test Plan:
1. Reset then no bus activity -> o_busy=0, o_start=0, o_byte_cnt=0, state IDLE. Release reset with done=1 -> no o_start pulse.
2. START on chb[1], write address 0xA0 (R/W bit 0) -> o_start ×8 with o_tx_to_mst=0. Bit 9 (ACK) has o_tx_to_mst=1. After bit 9 completes, o_byte_cnt=1.
3. Address 0xA1 read with ACK=0 -> data bits 10–17 have o_tx_to_mst=1; master-ACK bit 18 has o_tx_to_mst=0. Repeat for 3 bytes -> o_byte_cnt=4.
4. Address write with NACK (i_rx_sda_init=1 at bit 9) -> ack_failed=1. Subsequent bits have o_tx_to_mst=0 except ACK slots.
5. Repeated START mid-byte (bit_cnt=5) on cha, and simultaneous START+STOP on different buses -> START wins: bit_cnt=0, byte_cnt=0, state MST_RX_WAIT. Then a STOP -> o_busy=0 next cycle.
6. With I2C_PASSTHRU_TIMEOUT_EN and TIMEOUT_CYC=20, hold i_rx_done=0 -> o_timeout=1 after 21 cycles in WAIT. Then a START -> o_timeout=0, normal sequencing resumes. BYTE_CNT_W=2, 5 bytes -> o_byte_cnt=3.

Source files
------------

// File: rtl/i2c_passthru_dir_ctrl_mc.sv
// Per-bit SDA direction and bit-sequencing controller for a multi-channel I2C passthrough.
// Optional stuck-bit timeout is compiled in with `define I2C_PASSTHRU_TIMEOUT_EN.
module i2c_passthru_dir_ctrl_mc #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned BYTE_CNT_W  = 8,
  parameter int unsigned TIMEOUT_W   = 16,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cha_scl,
  input  logic                  i_cha_sda,
  input  logic [NUM_CH-1:0]     i_chb_scl,
  input  logic [NUM_CH-1:0]     i_chb_sda,
  input  logic                  i_rx_done,
  input  logic                  i_tx_done,
  input  logic                  i_rx_sda_init_valid,
  input  logic                  i_rx_sda_init,
  output logic                  o_start,
  output logic                  o_tx_to_mst,
  output logic                  o_busy,
  output logic [BYTE_CNT_W-1:0] o_byte_cnt,
  output logic                  o_timeout
);

`ifdef I2C_PASSTHRU_TIMEOUT_EN
  typedef enum logic [2:0] {
    StIdle, StMstRxWait, StMstRxStart, StSlvRxWait, StSlvRxStart, StTimeout
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StMstRxWait, StMstRxStart, StSlvRxWait, StSlvRxStart
  } state_e;
`endif

  localparam logic [BYTE_CNT_W-1:0] ByteMax = '1;

  state_e                  state_q, state_d;
  logic [3:0]              bit_cnt_q, bit_cnt_d;
  logic                    first_byte_n_q, first_byte_n_d;
  logic                    read_mode_q, read_mode_d;
  logic                    ack_failed_q, ack_failed_d;
  logic [BYTE_CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [NUM_CH:0]         sda_prev_q;

  logic [NUM_CH:0]         scl_all, sda_all;
  logic                    any_start, any_stop, bus_evt;
  logic                    slv_next, both_done, in_wait, in_start;

  // Index 0 is the upstream bus, 1..NUM_CH the downstream buses.
  assign scl_all   = {i_chb_scl, i_cha_scl};
  assign sda_all   = {i_chb_sda, i_cha_sda};
  assign any_start = |(scl_all & sda_prev_q & ~sda_all);
  assign any_stop  = |(scl_all & ~sda_prev_q & sda_all);
  assign bus_evt   = any_start | any_stop;

  assign both_done = i_rx_done & i_tx_done;
  assign in_wait   = (state_q == StMstRxWait) || (state_q == StSlvRxWait);
  assign in_start  = (state_q == StMstRxStart) || (state_q == StSlvRxStart);

  // Slave owns SDA for the ACK of a write byte and for data bits of an acknowledged read.
  assign slv_next = ((bit_cnt_q == 4'd8) && !read_mode_q) ||
                    ((bit_cnt_q != 4'd8) && read_mode_q && !ack_failed_q);

`ifdef I2C_PASSTHRU_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TmoLimit = TIMEOUT_W'(TIMEOUT_CYC);
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic                 tmo_hit;

  assign tmo_hit = (tmo_q == TmoLimit);

  always_comb begin
    tmo_d = tmo_q;
    if (bus_evt || o_start) begin
      tmo_d = '0;
    end else if (in_wait && !tmo_hit) begin
      tmo_d = tmo_q + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^{TIMEOUT_W, TIMEOUT_CYC};
`endif

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; bus START beats STOP beats normal sequencing.
  always_comb begin
    state_d = state_q;
    if (any_start) begin
      state_d = StMstRxWait;
    end else if (any_stop) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: state_d = StIdle;
        StMstRxWait, StSlvRxWait: begin
          if (both_done) begin
            state_d = slv_next ? StSlvRxStart : StMstRxStart;
          end
`ifdef I2C_PASSTHRU_TIMEOUT_EN
          else if (tmo_hit) begin
            state_d = StTimeout;
          end
`endif
        end
        StMstRxStart: state_d = StMstRxWait;
        StSlvRxStart: state_d = StSlvRxWait;
`ifdef I2C_PASSTHRU_TIMEOUT_EN
        StTimeout:    state_d = StTimeout;
`endif
        default:      state_d = StIdle;
      endcase
    end
  end

  // Outputs
  always_comb begin
    o_start     = in_start && !bus_evt;
    o_tx_to_mst = (state_q == StSlvRxWait) || (state_q == StSlvRxStart);
    o_busy      = (state_q != StIdle);
    o_byte_cnt  = byte_cnt_q;
`ifdef I2C_PASSTHRU_TIMEOUT_EN
    o_timeout   = (state_q == StTimeout);
`else
    o_timeout   = 1'b0;
`endif
  end

  // Bit/byte counters and transaction flags
  always_comb begin
    bit_cnt_d      = bit_cnt_q;
    first_byte_n_d = first_byte_n_q;
    read_mode_d    = read_mode_q;
    ack_failed_d   = ack_failed_q;
    byte_cnt_d     = byte_cnt_q;
    if (bus_evt) begin
      bit_cnt_d      = '0;
      first_byte_n_d = 1'b0;
      read_mode_d    = 1'b0;
      ack_failed_d   = 1'b0;
      byte_cnt_d     = '0;
    end else begin
      if (in_start) begin
        bit_cnt_d = (bit_cnt_q == 4'd9) ? 4'd1 : bit_cnt_q + 4'd1;
        if ((bit_cnt_q == 4'd9) && (byte_cnt_q != ByteMax)) begin
          byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
        end
      end
      if (bit_cnt_q == 4'd9) begin
        first_byte_n_d = 1'b1;
      end
      // R/W bit of the address byte selects read mode.
      if (i_rx_sda_init_valid && (bit_cnt_q == 4'd8) && !first_byte_n_q) begin
        read_mode_d = i_rx_sda_init;
      end
      if (i_rx_sda_init_valid && (bit_cnt_q == 4'd9) && !ack_failed_q) begin
        ack_failed_d = i_rx_sda_init;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bit_cnt_q      <= '0;
      first_byte_n_q <= 1'b0;
      read_mode_q    <= 1'b0;
      ack_failed_q   <= 1'b0;
      byte_cnt_q     <= '0;
      sda_prev_q     <= '1;
    end else begin
      bit_cnt_q      <= bit_cnt_d;
      first_byte_n_q <= first_byte_n_d;
      read_mode_q    <= read_mode_d;
      ack_failed_q   <= ack_failed_d;
      byte_cnt_q     <= byte_cnt_d;
      sda_prev_q     <= sda_all;
    end
  end

endmodule
